multi_edge_detect: RTL and testbench
====================================

Name: multi_edge_detect

Overview:
Parametrised N-channel edge detector; successor to the single-channel falling-edge detector.
- Per channel: input synchroniser, glitch filter, and a per-channel mode selecting rising, falling, both or off.
- Per channel: one-cycle edge pulse, sticky event flag and saturating edge counter.
- Sits between asynchronous pins/status lines and the interrupt/status logic; `any_event` is the aggregated interrupt request.

Parameters:
- N, 4, number of independent channels (>=1)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- FILT_CYC, 3, consecutive cycles a new level must persist before acceptance (>=1; 1 = no filtering)
- CNT_W, 8, width of each per-channel edge counter (>=1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- din  in  N  asynchronous raw inputs
- mode  in  2*N  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- flag_clr  in  N  per-channel sticky flag clear (single-cycle strobe or level)
- cnt_clr  in  N  per-channel counter clear
- level  out  N  filtered, synchronised level
- edge_pulse  out  N  one-cycle pulse on a mode-qualified edge
- rise  out  N  one-cycle pulse on any filtered rising edge, mode-independent
- fall  out  N  one-cycle pulse on any filtered falling edge, mode-independent
- event_flag  out  N  sticky, set by `edge_pulse`
- edge_cnt  out  N*CNT_W  per-channel counter, channel i at [(i+1)*CNT_W-1:i*CNT_W]
- any_event  out  1  OR of `event_flag`, registered

Behaviour:
- Reset (rst=1 at a clk edge): all sync flops, filter counters, `level`, `edge_pulse`, `rise`, `fall`, `event_flag`, `edge_cnt` and `any_event` go to 0. Reset overrides every other input.
- After reset, a channel whose `din` is 1 reports a rising edge once the normal latency elapses.
- Synchroniser: shift chain of SYNC_STAGES flops; `s` = last stage.
- Filter: per-channel counter fc, width clog2(FILT_CYC)+1.
  - If s == level: fc <= 0.
  - Else if fc == FILT_CYC-1: level <= s, fc <= 0.
  - Else: fc <= fc+1.
  - Any return of s to level before acceptance restarts the count (glitch rejected).
- Latency: a din change first sampled at edge k changes `level` at edge k+SYNC_STAGES+FILT_CYC-1.
  - `rise`/`fall` are registered and assert on that same edge, high for exactly one cycle.
- edge_pulse = (rise & mode[0]) | (fall & mode[1]), registered in the same cycle as `rise`/`fall`.
  - Mode is sampled in the cycle the edge is accepted.
  - A mode change never affects filter state.
  - Mode 00 suppresses `edge_pulse`, flag and counter, but `level`/`rise`/`fall` still track.
- event_flag:
  - set on `edge_pulse`;
  - cleared by `flag_clr`;
  - set wins when both occur in the same cycle.
- edge_cnt increments on each `edge_pulse` and saturates at 2^CNT_W-1 (no wrap).
  - `cnt_clr` takes it to 0.
  - `cnt_clr` together with `edge_pulse` in the same cycle gives 1.
- any_event = OR of the `event_flag` next-state; asserts in the same cycle as the first flag.
- Channels are fully independent; simultaneous edges on all N channels are each counted.
- Reset asserted mid-filter: the pending edge is discarded, with no pulse after reset release unless din still differs from 0.

Decomposition:
- Package `multi_edge_pkg`:
  - mode constants MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11;
  - a clog2 helper function.
- Sub-module `edge_chan`: one channel (sync chain, filter, rise/fall, flag, counter), with parameters SYNC_STAGES, FILT_CYC, CNT_W.
- Top generates N instances, slices the `mode`/`edge_cnt` buses and registers `any_event`.

Test Plan:
All scenarios use N=4, SYNC_STAGES=2, FILT_CYC=3, CNT_W=4.
1. Glitch rejection: ch0 mode=01, din[0]=1 for 2 clk then 0 -> `level[0]` stays 0; no `rise`/`edge_pulse`; `edge_cnt[0]`=0.
2. Latency and falling-only mode: ch1 mode=10, din[1] 0->1, held 10 clk, then ->0; first sample at edge k.
   - `rise[1]` at edge k+4 with `edge_pulse[1]`=0.
   - The falling change gives `fall[1]`, `edge_pulse[1]`, `event_flag[1]` and `any_event`=1 at +4; `edge_cnt[1]`=1.
3. Both-edge counting and saturation: ch2 mode=11, 20 clean toggles of 8 clk each -> 20 pulses; `edge_cnt[2]` reads 15 and holds.
4. Clear collisions:
   - `cnt_clr[2]` and `flag_clr[2]` asserted in the cycle of an `edge_pulse[2]` -> `edge_cnt[2]`=1, `event_flag[2]`=1.
   - The next cycle, `flag_clr[2]` alone -> `event_flag[2]`=0 and `any_event`=0 if all flags are clear.
5. Mode off and simultaneous edges: ch3 mode=00, all four din rise together -> `rise`=4'b1111, `edge_pulse`=4'b0111 (ch0, ch1 and ch2 must be in rise-enabled modes), `edge_cnt[3]`=0.
6. Reset mid-operation:
   - Raise din[0], assert rst for 1 clk two edges later -> all outputs 0 after that edge.
   - din[0] still 1 -> `rise[0]` at 5 edges after reset release (2 sync + 3 filter).

Source files
------------

// File: rtl/multi_edge_pkg.sv
// Shared definitions for the multi-channel edge detector.
package multi_edge_pkg;

    // Per-channel mode encoding, one 2-bit field per channel on the mode bus.
    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Ceiling log2 for sizing counters from parameters (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One edge-detect channel: synchroniser, glitch filter, rise/fall detection,
// mode qualification, sticky event flag and saturating edge counter.
//
// Output protocol: level, rise, fall and edge_pulse are registered. rise,
// fall and edge_pulse are one-cycle "valid" strobes with no back-pressure
// (no ready); a consumer must sample them on every clock edge or lose them.
// event_flag and edge_cnt hold the result until cleared.
module edge_chan
    import multi_edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 3,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic [1:0]       mode,
    input  logic             flag_clr,
    input  logic             cnt_clr,
    output logic             level,
    output logic             edge_pulse,
    output logic             rise,
    output logic             fall,
    output logic             event_flag,
    output logic             flag_next,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int               FC_W    = clog2(FILT_CYC) + 1;
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    logic [FC_W-1:0]        fc_q, fc_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   edge_q, edge_d;
    logic                   flag_q, flag_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Synchroniser shift chain; s is the last (metastability-safe) stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        s      = sync_q[SYNC_STAGES-1];
    end

    // Glitch filter: a new level is accepted only after FILT_CYC consecutive
    // cycles of disagreement; any return to the current level restarts it.
    always_comb begin
        fc_d    = fc_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s == level_q) begin
            fc_d = '0;
        end else if (fc_q == FC_LAST) begin
            level_d = s;
            fc_d    = '0;
            rise_d  = s;
            fall_d  = ~s;
        end else begin
            fc_d = fc_q + FC_W'(1);
        end
    end

    // Mode qualification, sampled in the cycle the edge is accepted.
    always_comb begin
        edge_d = 1'b0;
        case (mode)
            MODE_OFF:  edge_d = 1'b0;
            MODE_RISE: edge_d = rise_d;
            MODE_FALL: edge_d = fall_d;
            MODE_BOTH: edge_d = rise_d | fall_d;
            default:   edge_d = 1'b0;
        endcase
    end

    // Sticky flag (set beats clear) and saturating counter (clear plus
    // simultaneous edge leaves a count of one).
    always_comb begin
        flag_d = edge_d | (flag_q & ~flag_clr);
        cnt_d  = cnt_q;
        if (cnt_clr) begin
            cnt_d = edge_d ? CNT_W'(1) : '0;
        end else if (edge_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset; reset discards any pending edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            fc_q    <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            edge_q  <= 1'b0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            fc_q    <= fc_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            edge_q  <= edge_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level      = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign edge_pulse = edge_q;
    assign event_flag = flag_q;
    assign flag_next  = flag_d;
    assign edge_cnt   = cnt_q;

endmodule

// File: rtl/multi_edge_detect.sv
// N-channel edge detector: independent edge_chan instances plus a registered
// interrupt request that is the OR of all sticky event flags.
module multi_edge_detect
    import multi_edge_pkg::*;
#(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 3,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       din,
    input  logic [2*N-1:0]     mode,
    input  logic [N-1:0]       flag_clr,
    input  logic [N-1:0]       cnt_clr,
    output logic [N-1:0]       level,
    output logic [N-1:0]       edge_pulse,
    output logic [N-1:0]       rise,
    output logic [N-1:0]       fall,
    output logic [N-1:0]       event_flag,
    output logic [N*CNT_W-1:0] edge_cnt,
    output logic               any_event
);

    logic [N-1:0] flag_next;
    logic         any_q, any_d;

    for (genvar i = 0; i < N; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYC    (FILT_CYC),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .din        (din[i]),
            .mode       (mode[2*i +: 2]),
            .flag_clr   (flag_clr[i]),
            .cnt_clr    (cnt_clr[i]),
            .level      (level[i]),
            .edge_pulse (edge_pulse[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .event_flag (event_flag[i]),
            .flag_next  (flag_next[i]),
            .edge_cnt   (edge_cnt[i*CNT_W +: CNT_W])
        );
    end

    // Built from the flags' next state so the request rises with the first flag.
    always_comb begin
        any_d = |flag_next;
    end

    // Registered interrupt request.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_q <= 1'b0;
        end else begin
            any_q <= any_d;
        end
    end

    assign any_event = any_q;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Bench for multi_edge_detect: directed scenarios followed by random traffic,
// checked against a window-based reference model through an expected queue.
module tb_multi_edge_detect;

    localparam int N     = 4;
    localparam int SYNC  = 2;
    localparam int FILT  = 3;
    localparam int CNT_W = 4;
    localparam int MW    = 2 * N;
    localparam int W     = 5 * N + N * CNT_W + 1;
    localparam int HLEN  = SYNC + FILT;
    localparam int CMAX  = (1 << CNT_W) - 1;

    // ---------------- clock / reset / signals ----------------
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       din = '0;
    logic [MW-1:0]      mode = '0;
    logic [N-1:0]       flag_clr = '0;
    logic [N-1:0]       cnt_clr = '0;
    logic [N-1:0]       level, edge_pulse, rise, fall, event_flag;
    logic [N*CNT_W-1:0] edge_cnt;
    logic               any_event;

    always #5 clk = ~clk;

    multi_edge_detect #(
        .N           (N),
        .SYNC_STAGES (SYNC),
        .FILT_CYC    (FILT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .mode       (mode),
        .flag_clr   (flag_clr),
        .cnt_clr    (cnt_clr),
        .level      (level),
        .edge_pulse (edge_pulse),
        .rise       (rise),
        .fall       (fall),
        .event_flag (event_flag),
        .edge_cnt   (edge_cnt),
        .any_event  (any_event)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [W-1:0] exp_q[$];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A channel accepts a new level when the synchronised input has disagreed
    // with the accepted level for FILT consecutive samples. hist[j] holds the
    // din sampled j edges ago; the synchroniser makes hist[SYNC..HLEN-1] the
    // window seen by the filter.
    logic [N-1:0] hist [HLEN];
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_rise, m_fall, m_edge;
    logic [N-1:0] m_flag = '0;
    int           m_cnt [N];
    logic         m_any;
    logic         all_diff;
    logic [N*CNT_W-1:0] m_cnt_vec;

    always @(posedge clk) begin
        m_rise = '0;
        m_fall = '0;
        m_edge = '0;
        if (rst) begin
            for (int j = 0; j < HLEN; j++) hist[j] = '0;
            m_level = '0;
            m_flag  = '0;
            for (int c = 0; c < N; c++) m_cnt[c] = 0;
        end else begin
            for (int j = HLEN - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = din;
            for (int c = 0; c < N; c++) begin
                all_diff = 1'b1;
                for (int w = SYNC; w < HLEN; w++)
                    if (hist[w][c] == m_level[c]) all_diff = 1'b0;
                m_rise[c] = all_diff && !m_level[c];
                m_fall[c] = all_diff && m_level[c];
                if (all_diff) m_level[c] = !m_level[c];
                m_edge[c] = (m_rise[c] && mode[2*c]) || (m_fall[c] && mode[2*c+1]);
                if (m_edge[c]) m_flag[c] = 1'b1;
                else if (flag_clr[c]) m_flag[c] = 1'b0;
                if (cnt_clr[c]) m_cnt[c] = m_edge[c] ? 1 : 0;
                else if (m_edge[c] && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
            end
        end
        m_any = |m_flag;
        for (int c = 0; c < N; c++) m_cnt_vec[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        exp_q.push_back({m_any, m_cnt_vec, m_flag, m_fall, m_rise, m_edge, m_level});
    end

    // ---------------- scoreboard monitor ----------------
    logic [W-1:0] e, a;
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {any_event, edge_cnt, event_flag, fall, rise, edge_pulse, level};
            cmp("sb_level", 64'(a[0*N +: N]), 64'(e[0*N +: N]));
            cmp("sb_edge_pulse", 64'(a[1*N +: N]), 64'(e[1*N +: N]));
            cmp("sb_rise", 64'(a[2*N +: N]), 64'(e[2*N +: N]));
            cmp("sb_fall", 64'(a[3*N +: N]), 64'(e[3*N +: N]));
            cmp("sb_event_flag", 64'(a[4*N +: N]), 64'(e[4*N +: N]));
            cmp("sb_edge_cnt", 64'(a[5*N +: N*CNT_W]), 64'(e[5*N +: N*CNT_W]));
            cmp("sb_any_event", 64'(a[W-1]), 64'(e[W-1]));
        end
    end

    // ---------------- driver tasks ----------------
    // Offset (0-based) of the edge showing the pulse, counting the first edge
    // after the call as 0; -1 if it never appears within the budget.
    task automatic wait_edge(input int ch, input bit rising, output int off);
        off = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (rising ? rise[ch] : fall[ch]) begin
                off = i;
                break;
            end
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout at cycle %0d: got no finish, expected finish", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus and final report ----------------
    initial begin
        int off;
        rst  = 1'b1;
        mode = 8'b00_11_10_01;
        ticks(3);
        rst = 1'b0;
        cmp("reset_level", 64'(level), 64'(0));
        cmp("reset_cnt", 64'(edge_cnt), 64'(0));
        cmp("reset_any", 64'(any_event), 64'(0));

        // Glitch of two cycles on ch0 must be rejected.
        din[0] = 1'b1;
        ticks(2);
        din[0] = 1'b0;
        ticks(10);
        cmp("glitch_level0", 64'(level[0]), 64'(0));
        cmp("glitch_cnt0", 64'(edge_cnt[3:0]), 64'(0));

        // Latency and falling-only mode on ch1.
        din[1] = 1'b1;
        wait_edge(1, 1'b1, off);
        cmp("lat_rise1", 64'(off), 64'(4));
        cmp("fallmode_no_pulse1", 64'(edge_pulse[1]), 64'(0));
        ticks(6);
        din[1] = 1'b0;
        wait_edge(1, 1'b0, off);
        cmp("lat_fall1", 64'(off), 64'(4));
        cmp("fall_pulse1", 64'(edge_pulse[1]), 64'(1));
        cmp("fall_flag1", 64'(event_flag[1]), 64'(1));
        cmp("fall_any", 64'(any_event), 64'(1));
        cmp("fall_cnt1", 64'(edge_cnt[7:4]), 64'(1));

        // Both-edge counting with saturation on ch2.
        ticks(4);
        for (int t = 0; t < 20; t++) begin
            din[2] = ~din[2];
            ticks(8);
        end
        ticks(4);
        cmp("sat_cnt2", 64'(edge_cnt[11:8]), 64'(15));

        // Clear collisions on ch2.
        flag_clr = '1;
        ticks(1);
        flag_clr = '0;
        ticks(1);
        cmp("flags_cleared", 64'(event_flag), 64'(0));
        din[2] = ~din[2];
        ticks(4);
        flag_clr[2] = 1'b1;
        cnt_clr[2]  = 1'b1;
        ticks(1);
        cnt_clr[2] = 1'b0;
        cmp("coll_pulse2", 64'(edge_pulse[2]), 64'(1));
        cmp("coll_cnt2", 64'(edge_cnt[11:8]), 64'(1));
        cmp("coll_flag2", 64'(event_flag[2]), 64'(1));
        ticks(1);
        flag_clr[2] = 1'b0;
        cmp("clr_flag2", 64'(event_flag[2]), 64'(0));
        cmp("clr_any", 64'(any_event), 64'(0));

        // Mode off on ch3 with simultaneous rises on all channels.
        din = '0;
        ticks(10);
        mode = 8'b00_11_01_01;
        ticks(1);
        din = '1;
        wait_edge(0, 1'b1, off);
        cmp("simul_lat", 64'(off), 64'(4));
        cmp("simul_rise", 64'(rise), 64'(4'hF));
        cmp("simul_pulse", 64'(edge_pulse), 64'(4'b0111));
        cmp("off_cnt3", 64'(edge_cnt[15:12]), 64'(0));

        // Reset in the middle of filtering a rise on ch0.
        ticks(2);
        din = '0;
        ticks(10);
        din[0] = 1'b1;
        ticks(2);
        rst = 1'b1;
        ticks(1);
        rst = 1'b0;
        cmp("mid_rst_level", 64'(level), 64'(0));
        cmp("mid_rst_rise", 64'(rise), 64'(0));
        cmp("mid_rst_pulse", 64'(edge_pulse), 64'(0));
        cmp("mid_rst_flag", 64'(event_flag), 64'(0));
        cmp("mid_rst_cnt", 64'(edge_cnt), 64'(0));
        cmp("mid_rst_any", 64'(any_event), 64'(0));
        wait_edge(0, 1'b1, off);
        cmp("post_rst_lat", 64'(off), 64'(4));

        // Random traffic: toggles, glitches, clears, mode changes, resets.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 5) == 0) din[c] = ~din[c];
                flag_clr[c] = ($urandom_range(0, 15) == 0);
                cnt_clr[c]  = ($urandom_range(0, 31) == 0);
            end
            if ($urandom_range(0, 63) == 0) mode = MW'($urandom);
            rst = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        rst      = 1'b0;
        flag_clr = '0;
        cnt_clr  = '0;
        ticks(5);
        #1;
        cmp("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
